// File: rtl/map_rom_arbiter.sv
// Shares one map ROM between the pixel-timed overlay and the latency-tolerant tracer.
// Two-stage pipeline: arbitrate and register the ROM address, then register ROM data and valid.
module map_rom_arbiter #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_ovl_req,
    input  logic [MAP_WIDTH_BITS-1:0]  i_ovl_col,
    input  logic [MAP_HEIGHT_BITS-1:0] i_ovl_row,
    output logic                       o_ovl_gnt,
    output logic                       o_ovl_valid,
    output logic                       o_ovl_val,
    output logic                       o_ovl_miss,
    input  logic                       i_trc_req,
    input  logic [MAP_WIDTH_BITS-1:0]  i_trc_col,
    input  logic [MAP_HEIGHT_BITS-1:0] i_trc_row,
    output logic                       o_trc_gnt,
    output logic                       o_trc_valid,
    output logic                       o_trc_val,
    output logic [MAP_WIDTH_BITS-1:0]  o_rom_col,
    output logic [MAP_HEIGHT_BITS-1:0] o_rom_row,
    input  logic                       i_rom_val
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_OVL  = 2'd1,
        TAG_TRC  = 2'd2
    } tag_t;

    logic [7:0]                 r_starve_cnt;
    tag_t                       r_tag_a;
    logic [MAP_WIDTH_BITS-1:0]  r_rom_col;
    logic [MAP_HEIGHT_BITS-1:0] r_rom_row;
    logic                       r_ovl_valid;
    logic                       r_ovl_val;
    logic                       r_trc_valid;
    logic                       r_trc_val;

    logic w_force;
    logic w_ovl_gnt;
    logic w_trc_gnt;
    logic w_ovl_miss;

    // Grants are qualified with reset so nothing is accepted while the pipeline is held clear.
    always_comb begin
        w_force    = i_reset_n && i_trc_req && (r_starve_cnt == LIMIT);
        w_ovl_gnt  = i_reset_n && i_ovl_req && !w_force;
        w_trc_gnt  = i_reset_n && i_trc_req && (w_force || !i_ovl_req);
        w_ovl_miss = w_force && i_ovl_req;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rom_col <= '0;
            r_rom_row <= '0;
            r_tag_a   <= TAG_NONE;
        end else if (w_ovl_gnt) begin
            r_rom_col <= i_ovl_col;
            r_rom_row <= i_ovl_row;
            r_tag_a   <= TAG_OVL;
        end else if (w_trc_gnt) begin
            r_rom_col <= i_trc_col;
            r_rom_row <= i_trc_row;
            r_tag_a   <= TAG_TRC;
        end else begin
            r_tag_a   <= TAG_NONE;
        end
    end

    // ROM data is routed by the stage-A tag; the non-owning result register keeps its value.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovl_valid <= 1'b0;
            r_ovl_val   <= 1'b0;
            r_trc_valid <= 1'b0;
            r_trc_val   <= 1'b0;
        end else begin
            r_ovl_valid <= (r_tag_a == TAG_OVL);
            r_trc_valid <= (r_tag_a == TAG_TRC);
            if (r_tag_a == TAG_OVL) r_ovl_val <= i_rom_val;
            if (r_tag_a == TAG_TRC) r_trc_val <= i_rom_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if (!i_trc_req || w_trc_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign o_ovl_gnt   = w_ovl_gnt;
    assign o_trc_gnt   = w_trc_gnt;
    assign o_ovl_miss  = w_ovl_miss;
    assign o_ovl_valid = r_ovl_valid;
    assign o_ovl_val   = r_ovl_val;
    assign o_trc_valid = r_trc_valid;
    assign o_trc_val   = r_trc_val;
    assign o_rom_col   = r_rom_col;
    assign o_rom_row   = r_rom_row;

endmodule
